// File: rtl/seg7_snoop.sv
// seg7_snoop: passive snooper for a multiplexed 4-digit, 7-segment display.
// Samples {dig_en, seg}, waits for STABLE_CYC identical one-hot samples,
// decodes the segment pattern into a hex nibble and assembles 4-digit frames.
// Optional: define SEG7_SNOOP_ERRCNT_EN to add an 8-bit saturating err_cnt output.
module seg7_snoop #(
    parameter int unsigned STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  dig_en,
    output logic [15:0] val,
    output logic        val_vld,
    output logic        err
`ifdef SEG7_SNOOP_ERRCNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam logic [7:0] CNT_LIM = STABLE_CYC[7:0];

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] sample_q, sample_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] val_q, val_d;
    logic        val_vld_q, val_vld_d;
    logic        err_q, err_d;

    logic        onehot;
    logic [1:0]  slot;
    logic        capture;
    logic        dec_ok;
    logic [3:0]  dec_nib;

    // Segment pattern (a..g on seg[6:0]) to hex nibble, plus a validity flag
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E:   decode = {1'b1, 4'h0};
            7'h30:   decode = {1'b1, 4'h1};
            7'h6D:   decode = {1'b1, 4'h2};
            7'h79:   decode = {1'b1, 4'h3};
            7'h33:   decode = {1'b1, 4'h4};
            7'h5B:   decode = {1'b1, 4'h5};
            7'h5F:   decode = {1'b1, 4'h6};
            7'h70:   decode = {1'b1, 4'h7};
            7'h7F:   decode = {1'b1, 4'h8};
            7'h7B:   decode = {1'b1, 4'h9};
            7'h77:   decode = {1'b1, 4'hA};
            7'h1F:   decode = {1'b1, 4'hB};
            7'h4E:   decode = {1'b1, 4'hC};
            7'h3D:   decode = {1'b1, 4'hD};
            7'h6F:   decode = {1'b1, 4'hE};
            7'h47:   decode = {1'b1, 4'hF};
            default: decode = {1'b0, 4'h0};
        endcase
    endfunction

    // Digit-select qualification and slot index
    always_comb begin
        onehot = (dig_en != 4'b0000) && ((dig_en & (dig_en - 4'd1)) == 4'b0000);
        case (dig_en)
            4'b0010: slot = 2'd1;
            4'b0100: slot = 2'd2;
            4'b1000: slot = 2'd3;
            default: slot = 2'd0;
        endcase
        {dec_ok, dec_nib} = decode(seg);
    end

    // Stability FSM, capture, and frame assembly
    always_comb begin
        state_d   = state_q;
        sample_d  = {dig_en, seg};
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        shadow_d  = shadow_q;
        val_d     = val_q;
        val_vld_d = 1'b0;
        err_d     = 1'b0;
        capture   = 1'b0;

        if (!onehot) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (({dig_en, seg} != sample_q) || (state_q == IDLE)) begin
            cnt_d = 8'd1;
            if (STABLE_CYC == 1) begin
                capture = 1'b1;
                state_d = HOLD;
            end else begin
                state_d = SETTLE;
            end
        end else if (state_q == SETTLE) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_d == CNT_LIM) begin
                capture = 1'b1;
                state_d = HOLD;
            end
        end

        if (capture) begin
            if (dec_ok) begin
                shadow_d[{slot, 2'b00} +: 4] = dec_nib;
                mask_d = mask_q | dig_en;
                if (mask_d == 4'b1111) begin
                    val_d     = shadow_d;
                    val_vld_d = 1'b1;
                    mask_d    = '0;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // State registers; reset wins over any capture on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sample_q  <= '0;
            cnt_q     <= '0;
            mask_q    <= '0;
            shadow_q  <= '0;
            val_q     <= '0;
            val_vld_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sample_q  <= sample_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            shadow_q  <= shadow_d;
            val_q     <= val_d;
            val_vld_q <= val_vld_d;
            err_q     <= err_d;
        end
    end

    assign val     = val_q;
    assign val_vld = val_vld_q;
    assign err     = err_q;

`ifdef SEG7_SNOOP_ERRCNT_EN
    logic [7:0] errcnt_q, errcnt_d;

    // Saturating count of invalid captures
    always_comb begin
        errcnt_d = errcnt_q;
        if (err_d && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    // Error counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign err_cnt = errcnt_q;
`endif

endmodule

// File: doc/seg7_snoop.md
SEG7_SNOOP -- requirements
Module: seg7_snoop

Interface
REQ-001 SHALL have parameter: STABLE_CYC, default 4, number of consecutive identical one-hot samples required before capture (legal 1..255).
REQ-002 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: seg  input  7  active-high segment pattern, seg[6]=a ... seg[0]=g.
REQ-005 SHALL have port: dig_en  input  4  active-high digit select; one-hot when valid; bit n = digit n.
REQ-006 SHALL have port: val  output  16  last complete captured frame; digit n in val[4n+3:4n].
REQ-007 SHALL have port: val_vld  output  1  one-cycle pulse when val updates.
REQ-008 SHALL have port: err  output  1  one-cycle pulse when a capture finds an undecodable pattern.

Function
REQ-009 SHALL decode patterns: 7E->0, 30->1, 6D->2, 79->3, 33->4, 5B->5, 5F->6, 70->7, 7F->8, 7B->9, 77->A, 1F->B, 4E->C, 3D->D, 6F->E, 47->F (hex seg[6:0]); every other pattern is invalid.
REQ-010 SHALL run a 3-state FSM: IDLE (dig_en not one-hot), SETTLE (counting stable samples), HOLD (captured; awaiting input change).
REQ-011 SHALL register {dig_en,seg} each edge and compare with the previous sample; any difference restarts counting.
REQ-012 SHALL, from IDLE or HOLD, enter SETTLE with count=1 on the first edge sampling a one-hot dig_en that differs from the prior sample.
REQ-013 SHALL increment count in SETTLE on each edge sampling identical one-hot inputs; capture on the edge count reaches STABLE_CYC, then enter HOLD.
REQ-014 SHALL go to IDLE and clear count on any edge sampling dig_en == 0 or with more than one bit set; no capture occurs.
REQ-015 SHALL capture exactly once per stable period; HOLD ignores identical samples indefinitely.
REQ-016 SHALL, on valid capture, write the decoded nibble into slot n of a shadow register and set captured-mask bit n.
REQ-017 SHALL, on invalid capture, pulse err for one cycle; shadow slot and mask bit are left unchanged.
REQ-018 SHALL allow recapture of an already-captured digit before frame completion: slot overwritten, mask unchanged.
REQ-019 SHALL, on the edge the mask becomes 4'b1111, load val from the shadow (including the just-written nibble), pulse val_vld the following cycle, and clear the mask.
REQ-020 SHALL keep val stable between val_vld pulses; val_vld and err never assert for more than one consecutive cycle per event.
REQ-021 SHALL, with STABLE_CYC=1, capture on the first edge sampling a new one-hot input.

Reset
REQ-022 SHALL on rst sampled high: val=16'h0000, val_vld=0, err=0, mask=0, shadow=0, count=0, sample register=0, FSM=IDLE.
REQ-023 SHALL abandon a partial frame on reset mid-operation; no val_vld for that frame.
REQ-024 SHALL give rst priority over any simultaneous capture or frame completion.

Configuration
REQ-025 SHALL, when SEG7_SNOOP_ERRCNT_EN is defined, add output err_cnt (8 bits) counting invalid captures, saturating at 8'hFF, cleared only by rst.
REQ-026 SHALL, when SEG7_SNOOP_ERRCNT_EN is undefined, omit err_cnt and its counter entirely; all other behaviour is identical.

Verification
REQ-027 SHALL cover: STABLE_CYC=4; digits 0..3 driven seg=30,6D,79,33, each held 6 cycles -> one val_vld, val=16'h4321.
REQ-028 SHALL cover: digit 0 seg=7E held only 3 cycles then digit 1 -> no digit-0 capture; mask bit 0 stays clear; no val_vld.
REQ-029 SHALL cover: digit 2 seg=7'h00 held 5 cycles -> single err pulse; err_cnt=1 if SEG7_SNOOP_ERRCNT_EN; frame incomplete.
REQ-030 SHALL cover: dig_en=4'b0011 held 10 cycles -> FSM stays IDLE, no capture, no err.
REQ-031 SHALL cover: rst asserted after digits 0,1 captured, then full frame 7F,5B,4E,47 -> val=16'hFC58 with exactly one val_vld.
REQ-032 SHALL cover: digit 3 captured 4E then 77 before frame completes, remaining digits 7E -> val=16'hA000.
